// File: rtl/imm_gen_pkg.sv
// Shared constants for the decode-stage immediate generator: imm_sel encodings
// and the legal datapath widths.
package imm_gen_pkg;

  localparam logic [2:0] IMM_I    = 3'b000;
  localparam logic [2:0] IMM_LD   = 3'b001;
  localparam logic [2:0] IMM_S    = 3'b010;
  localparam logic [2:0] IMM_R    = 3'b011;
  localparam logic [2:0] IMM_B    = 3'b100;
  localparam logic [2:0] IMM_U    = 3'b101;
  localparam logic [2:0] IMM_JALR = 3'b110;
  localparam logic [2:0] IMM_J    = 3'b111;

  localparam int D_W_RV32 = 32;
  localparam int D_W_RV64 = 64;

  function automatic bit d_w_legal(input int w);
    return (w == D_W_RV32) || (w == D_W_RV64);
  endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational RISC-V immediate decode from instruction bits [31:7].
// Optional macro IMM_GEN_CSR_ZIMM_EN makes imm_sel=011 return the CSR zimm.
module imm_decode #(
  parameter int D_W = 32
) (
  input  logic [2:0]     imm_sel,
  input  logic [24:0]    upper_inst,
  output logic [D_W-1:0] imm
);
  import imm_gen_pkg::*;

  logic        s;
  logic [31:0] imm32;

  assign s = upper_inst[24];

  // Every format fits in 32 bits and zimm has bit 31 clear, so a single
  // sign extension to D_W is correct for all selects.
  always_comb begin
    imm32 = '0;
    case (imm_sel)
      IMM_I, IMM_LD, IMM_JALR: imm32 = {{20{s}}, upper_inst[24:13]};
      IMM_S:    imm32 = {{20{s}}, upper_inst[24:18], upper_inst[4:0]};
      IMM_B:    imm32 = {{19{s}}, s, upper_inst[0], upper_inst[23:18],
                         upper_inst[4:1], 1'b0};
      IMM_U:    imm32 = {upper_inst[24:5], 12'b0};
      IMM_J:    imm32 = {{11{s}}, s, upper_inst[12:5], upper_inst[13],
                         upper_inst[23:14], 1'b0};
`ifdef IMM_GEN_CSR_ZIMM_EN
      IMM_R:    imm32 = {27'b0, upper_inst[12:8]};
`else
      IMM_R:    imm32 = '0;
`endif
      default:  imm32 = '0;
    endcase
  end

  assign imm = D_W'(signed'(imm32));

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate generator feeding a 2-entry skid buffer with registered in_ready.
// Optional macro IMM_GEN_CSR_ZIMM_EN enables CSR zimm decode for imm_sel=011.
module imm_gen_pipe #(
  parameter int D_W   = 32,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       imm_sel,
  input  logic [24:0]      upper_inst,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [D_W-1:0]   out_imm,
  output logic [TAG_W-1:0] out_tag
);
  import imm_gen_pkg::*;

  if (!d_w_legal(D_W)) begin : g_bad_d_w
    $error("imm_gen_pipe: D_W must be 32 or 64");
  end

  logic [D_W-1:0]   dec_imm;
  logic [D_W-1:0]   mem_imm [2];
  logic [TAG_W-1:0] mem_tag [2];
  logic             head;
  logic             tail;
  logic [1:0]       count;
  logic [1:0]       count_next;
  logic             push;
  logic             pop;

  imm_decode #(.D_W(D_W)) u_decode (
    .imm_sel    (imm_sel),
    .upper_inst (upper_inst),
    .imm        (dec_imm)
  );

  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_valid = (count != 2'd0);
  assign out_imm   = mem_imm[head];
  assign out_tag   = mem_tag[head];

  always_comb begin
    count_next = count + {1'b0, push} - {1'b0, pop};
  end

  // in_ready is registered from the post-edge count so it never depends
  // combinationally on out_ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      count      <= 2'd0;
      head       <= 1'b0;
      tail       <= 1'b0;
      in_ready   <= 1'b1;
      mem_imm[0] <= '0;
      mem_imm[1] <= '0;
      mem_tag[0] <= '0;
      mem_tag[1] <= '0;
    end else if (flush) begin
      count    <= 2'd0;
      head     <= 1'b0;
      tail     <= 1'b0;
      in_ready <= 1'b1;
    end else begin
      if (push) begin
        mem_imm[tail] <= dec_imm;
        mem_tag[tail] <= in_tag;
        tail          <= ~tail;
      end
      if (pop) begin
        head <= ~head;
      end
      count    <= count_next;
      in_ready <= (count_next != 2'd2);
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: RV32 and RV64 instances share stimulus
// and are checked against a queue-based model built from the ISA field layout.
module tb_imm_gen_pipe;
  import imm_gen_pkg::*;

  typedef struct {
    logic [63:0] imm;
    logic [31:0] tag;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [2:0]  imm_sel = 3'b0;
  logic [24:0] upper_inst = '0;
  logic [31:0] in_tag = '0;
  logic        out_ready = 1'b0;

  logic        in_ready32, out_valid32, in_ready64, out_valid64;
  logic [31:0] out_imm32, out_tag32, out_tag64;
  logic [63:0] out_imm64;

  int n_checks = 0;
  int n_fail = 0;

  ent_t q[$];
  bit   cleared = 1'b0;
  bit   model_live = 1'b0;

  imm_gen_pipe #(.D_W(32), .TAG_W(32)) dut32 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready32), .imm_sel(imm_sel), .upper_inst(upper_inst),
    .in_tag(in_tag), .out_valid(out_valid32), .out_ready(out_ready),
    .out_imm(out_imm32), .out_tag(out_tag32)
  );

  imm_gen_pipe #(.D_W(64), .TAG_W(32)) dut64 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready64), .imm_sel(imm_sel), .upper_inst(upper_inst),
    .in_tag(in_tag), .out_valid(out_valid64), .out_ready(out_ready),
    .out_imm(out_imm64), .out_tag(out_tag64)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] got,
                             input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Reference immediate built from the full 32-bit instruction word with
  // arithmetic shifts, following the ISA's published bit scatter.
  function automatic logic [63:0] ref_imm(input logic [2:0] sel,
                                          input logic [24:0] u);
    logic [31:0] ins;
    longint      sx;
    longint      v;
    ins = {u, 7'h13};
    sx  = longint'($signed(ins));
    case (sel)
      IMM_I, IMM_LD, IMM_JALR: v = sx >>> 20;
      IMM_S: v = ((sx >>> 25) <<< 5) | longint'(ins[11:7]);
      IMM_B: v = ((sx >>> 31) <<< 12) | (longint'(ins[7]) << 11)
                 | (longint'(ins[30:25]) << 5) | (longint'(ins[11:8]) << 1);
      IMM_U: v = (sx >>> 12) <<< 12;
      IMM_J: v = ((sx >>> 31) <<< 20) | (longint'(ins[19:12]) << 12)
                 | (longint'(ins[20]) << 11) | (longint'(ins[30:21]) << 1);
`ifdef IMM_GEN_CSR_ZIMM_EN
      default: v = longint'(ins[19:15]);
`else
      default: v = 0;
`endif
    endcase
    return 64'(v);
  endfunction

  function automatic logic [24:0] up(input logic [31:0] i);
    return i[31:7];
  endfunction

  always @(posedge clk) begin
    int   n;
    ent_t e;
    if (reset) begin
      q.delete();
      cleared    = 1'b1;
      model_live = 1'b1;
    end else if (flush) begin
      q.delete();
    end else begin
      n = q.size();
      if (n > 0 && out_ready) void'(q.pop_front());
      if (in_valid && n < 2) begin
        e.imm = ref_imm(imm_sel, upper_inst);
        e.tag = in_tag;
        q.push_back(e);
        cleared = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    ent_t h;
    if (model_live) begin
      checkOutput("out_valid32", 64'(out_valid32), 64'(q.size() != 0));
      checkOutput("in_ready32", 64'(in_ready32), 64'(q.size() < 2));
      checkOutput("out_valid64", 64'(out_valid64), 64'(q.size() != 0));
      checkOutput("in_ready64", 64'(in_ready64), 64'(q.size() < 2));
      if (q.size() != 0) begin
        h = q[0];
        checkOutput("imm32", 64'(out_imm32), 64'(h.imm[31:0]));
        checkOutput("imm64", out_imm64, h.imm);
        checkOutput("tag32", 64'(out_tag32), 64'(h.tag));
        checkOutput("tag64", 64'(out_tag64), 64'(h.tag));
      end else if (cleared) begin
        checkOutput("rst_imm32", 64'(out_imm32), 64'd0);
        checkOutput("rst_imm64", out_imm64, 64'd0);
        checkOutput("rst_tag32", 64'(out_tag32), 64'd0);
      end
    end
  end

  task automatic applyStimulus(input logic v, input logic [2:0] sel,
                               input logic [24:0] u, input logic [31:0] tag,
                               input logic ordy, input logic fl);
    in_valid   = v;
    imm_sel    = sel;
    upper_inst = u;
    in_tag     = tag;
    out_ready  = ordy;
    flush      = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(0, IMM_I, '0, 0, 0, 0);
    applyStimulus(0, IMM_I, '0, 0, 0, 0);
    reset = 1'b0;
    checkOutput("reset_valid", 64'(out_valid32), 64'd0);
    checkOutput("reset_ready", 64'(in_ready32), 64'd1);

    applyStimulus(1, IMM_I, up(32'hFFF00093), 32'h11, 1, 0);
    checkOutput("addi_valid", 64'(out_valid32), 64'd1);
    checkOutput("addi_imm32", 64'(out_imm32), 64'hFFFF_FFFF);
    applyStimulus(1, IMM_S, up(32'hFE112E23), 32'h12, 1, 0);
    checkOutput("sw_imm32", 64'(out_imm32), 64'hFFFF_FFFC);
    applyStimulus(1, IMM_U, up(32'h123452B7), 32'h13, 1, 0);
    checkOutput("lui_imm32", 64'(out_imm32), 64'h1234_5000);
    applyStimulus(1, IMM_B, up(32'hFE000CE3), 32'h14, 1, 0);
    checkOutput("beq_imm64", out_imm64, 64'hFFFF_FFFF_FFFF_FFF8);
    applyStimulus(1, IMM_R, 25'h1F << 8, 32'h15, 1, 0);
`ifdef IMM_GEN_CSR_ZIMM_EN
    checkOutput("zimm_imm32", 64'(out_imm32), 64'h1F);
`else
    checkOutput("zimm_imm32", 64'(out_imm32), 64'h0);
`endif
    applyStimulus(0, IMM_I, '0, 0, 1, 0);
    checkOutput("drain_valid", 64'(out_valid32), 64'd0);

    // Stall: third push must be held off while out_tag stays on the head.
    applyStimulus(1, IMM_I, 25'h0123456, 1, 0, 0);
    checkOutput("stall1_ready", 64'(in_ready32), 64'd1);
    applyStimulus(1, IMM_S, 25'h1ABCDEF, 2, 0, 0);
    checkOutput("stall2_ready", 64'(in_ready32), 64'd0);
    checkOutput("stall2_tag", 64'(out_tag32), 64'd1);
    applyStimulus(1, IMM_J, 25'h0F0F0F0, 3, 0, 0);
    checkOutput("stall3_tag", 64'(out_tag32), 64'd1);
    checkOutput("stall3_ready", 64'(in_ready32), 64'd0);
    applyStimulus(1, IMM_J, 25'h0F0F0F0, 3, 1, 0);
    checkOutput("release_tag2", 64'(out_tag32), 64'd2);
    applyStimulus(1, IMM_J, 25'h0F0F0F0, 3, 1, 0);
    checkOutput("release_tag3", 64'(out_tag32), 64'd3);
    applyStimulus(0, IMM_I, '0, 0, 1, 0);
    checkOutput("release_empty", 64'(out_valid32), 64'd0);

    applyStimulus(1, IMM_I, 25'h1000000, 32'hA, 0, 0);
    applyStimulus(1, IMM_I, 25'h0800000, 32'hB, 0, 0);
    applyStimulus(1, IMM_I, 25'h0400000, 32'hC, 0, 1);
    checkOutput("flush_valid", 64'(out_valid32), 64'd0);
    checkOutput("flush_ready", 64'(in_ready32), 64'd1);
    applyStimulus(0, IMM_I, '0, 0, 1, 0);
    checkOutput("flush_idle", 64'(out_valid32), 64'd0);

    applyStimulus(1, IMM_B, 25'h1FFFFFF, 32'h55, 0, 0);
    applyStimulus(1, IMM_U, 25'h1234567, 32'h66, 0, 0);
    reset = 1'b1;
    applyStimulus(1, IMM_J, 25'h1555555, 32'h77, 1, 0);
    reset = 1'b0;
    checkOutput("midrst_valid", 64'(out_valid32), 64'd0);
    checkOutput("midrst_ready", 64'(in_ready32), 64'd1);
    checkOutput("midrst_imm64", out_imm64, 64'd0);
    checkOutput("midrst_tag", 64'(out_tag64), 64'd0);

    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom % 4) != 0, 3'($urandom), 25'($urandom),
                    $urandom, ($urandom % 10) < 7, ($urandom % 30) == 0);
    end
    applyStimulus(0, IMM_I, '0, 0, 1, 0);
    applyStimulus(0, IMM_I, '0, 0, 1, 0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
